modmul_operand_gen: RTL and testbench
=====================================

// Module: modmul_operand_gen
// PURPOSE
//  Upstream feeder for nonrestoringdiv in the RSA decryption datapath. Accepts X, Y, modulus N;
//  forms P = X*Y (2*WIDTH bits) with a bit-serial shift-add multiplier; presents the divider
//  launch operands A = P[2W-1:W], Q = P[W-1:0], M = N on a valid/ready output.
//  The divider's remainder is then X*Y mod N, the inner step of square-and-multiply.
// PARAMETERS
//  WIDTH  512  operand width W (X, Y, N, each output half); must be >= 2
//  CNT_W  10   iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//  clk        in   1      clock; all logic on posedge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand set X/Y/N valid
//  in_ready   out  1      block can accept an operand set
//  in_x       in   WIDTH  multiplicand X
//  in_y       in   WIDTH  multiplier Y
//  in_n       in   WIDTH  modulus N
//  out_valid  out  1      launch operands valid
//  out_ready  in   1      divider side consumed operands
//  out_a      out  WIDTH  accumulator seed = P[2W-1:W]
//  out_q      out  WIDTH  dividend low half = P[W-1:0]
//  out_m      out  WIDTH  divisor = latched N
//  busy       out  1      high in MUL or HOLD
//  err        out  1      operand range error (only with OPERAND_CHECK_EN)
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready=0 during reset, 1 on first cycle after; out_valid=0,
//    busy=0, err=0; out_a/out_q/out_m=0; internal X/Y/N/P/counter=0.
//  - FSM IDLE -> MUL -> HOLD -> IDLE. in_ready = (state==IDLE) && !rst.
//  - IDLE: on in_valid&&in_ready: latch X,Y,N; P=0; cnt=WIDTH; go MUL. Else hold.
//  - MUL: one bit per cycle, Y MSB-first: P <= (P<<1) + (y_msb ? {W'b0,X} : 0); Y <= Y<<1;
//    cnt <= cnt-1. On the cycle cnt==1 (last bit) go HOLD. Exactly WIDTH MUL cycles.
//  - Arithmetic: P is 2W bits, unsigned, never overflows (X,Y < 2^W); no truncation.
//  - Latency: out_valid rises exactly WIDTH+1 clock edges after the accepting edge
//    (1 load edge + WIDTH MUL edges); out_a/q/m stable whenever out_valid=1.
//  - HOLD: out_valid=1; outputs hold until out_valid&&out_ready, then IDLE next edge;
//    in_ready rises the cycle after the output handshake (no overlap, 1 op in flight).
//  - out_ready while not out_valid: ignored. in_valid while not in_ready: ignored,
//    upstream must hold operands until accepted.
//  - Range: if X<N and Y<N then out_a < N, satisfying the divider's A<M precondition;
//    without the check below, out-of-range input yields a well-formed P but an invalid division.
//  - rst mid-MUL or mid-HOLD: in-flight op discarded, all outputs to reset values next edge.
//  - X=0 or Y=0: full WIDTH cycles still run; P=0 emitted. N=0 passed through unchanged.
// CONFIGURATION
//  - OPERAND_CHECK_EN defined: at accept, if X>=N or Y>=N or N==0, latch err=1, skip MUL,
//    stay IDLE (in_ready stays 1); err clears on next accepted in-range op or rst.
//    No out_valid for the rejected op.
//  - OPERAND_CHECK_EN undefined: no comparators; err tied 0; all ops accepted.
// TESTING (WIDTH=8 unless noted)
//  - X=8'hC8,Y=8'hB4,N=8'hFB -> P=16'h8CA0: out_a=8'h8C,out_q=8'hA0,out_m=8'hFB; out_valid 9 edges after accept.
//  - out_ready held 0 for 5 cycles in HOLD -> outputs frozen, in_ready=0; on out_ready=1 -> IDLE, in_ready=1 next cycle.
//  - X=0,Y=8'hFF,N=8'hFF; then X=8'hFE,Y=8'hFE -> P=0, then P=16'hFC04; second accepted only after first handshake.
//  - rst asserted at MUL cycle 4 -> next edge out_valid=0,busy=0,outputs 0; new op after rst gives correct P.
//  - OPERAND_CHECK_EN: X=8'h10,Y=8'h05,N=8'h10 -> err=1, no out_valid, in_ready stays 1; next X=8'h03,Y=8'h05 -> err=0, P=16'h000F.
//  - WIDTH=512 chained into nonrestoringdiv with random X,Y<N -> divider R == X*Y mod N vs. model, 200 vectors.

Source files
------------

// File: rtl/modmul_operand_gen.sv
// Bit-serial shift-add multiplier producing the launch operands for a nonrestoring divider.
// Optional operand range checking is built in when OPERAND_CHECK_EN is defined.
module modmul_operand_gen #(
  parameter int WIDTH = 512,
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_q,
  output logic [WIDTH-1:0] out_m,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   x_q, x_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic [WIDTH-1:0]   n_q, n_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;
  logic               op_bad;
  logic [2*WIDTH-1:0] addend;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q != IDLE);
  assign out_a     = p_q[2*WIDTH-1:WIDTH];
  assign out_q     = p_q[WIDTH-1:0];
  assign out_m     = n_q;
  assign addend    = y_q[WIDTH-1] ? {{WIDTH{1'b0}}, x_q} : '0;

`ifdef OPERAND_CHECK_EN
  logic err_q;

  // A rejected operand set never leaves IDLE; err reflects the most recent accept.
  assign op_bad = (in_x >= in_n) || (in_y >= in_n) || (in_n == '0);
  assign err    = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= op_bad;
    end
  end
`else
  assign op_bad = 1'b0;
  assign err    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    n_d     = n_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept && !op_bad) begin
          x_d     = in_x;
          y_d     = in_y;
          n_d     = in_n;
          p_d     = '0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = MUL;
        end
      end
      MUL: begin
        // Y is consumed MSB-first, so P doubles before each conditional add of X.
        p_d   = (p_q << 1) + addend;
        y_d   = y_q << 1;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      n_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      n_q     <= n_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_modmul_operand_gen.sv
// Directed bench for modmul_operand_gen at WIDTH=8: table of products plus hold,
// mid-operation reset and (when OPERAND_CHECK_EN is defined) operand rejection.
module tb_modmul_operand_gen;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_x, in_y, in_n;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_a, out_q, out_m;
  logic         busy;
  logic         err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [W-1:0]   n;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[9];

  modmul_operand_gen #(.WIDTH(W), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_n      (in_n),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_q     (out_q),
    .out_m     (out_m),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one operand set, checks latency and results, holds HOLD for
  // hold_cycles extra cycles, then completes the output handshake.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [W-1:0] n,
                        input logic [2*W-1:0] ep, input int hold_cycles);
    int guard;
    int lat;
    @(negedge clk);
    in_x = x; in_y = y; in_n = n; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_timeout", 32'(guard < 50), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 32'd9);
    chk("out_a", 32'(out_a), 32'(ep[2*W-1:W]));
    chk("out_q", 32'(out_q), 32'(ep[W-1:0]));
    chk("out_m", 32'(out_m), 32'(n));
    chk("in_ready_hold", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold_cycles; i++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_a", 32'(out_a), 32'(ep[2*W-1:W]));
      chk("hold_q", 32'(out_q), 32'(ep[W-1:0]));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("post_hs_valid", 32'(out_valid), 32'd0);
    chk("post_hs_in_ready", 32'(in_ready), 32'd1);
    chk("post_hs_busy", 32'(busy), 32'd0);
    $display("op x=%h y=%h n=%h -> a=%h q=%h m=%h lat=%0d expect p=%h", x, y, n,
             ep[2*W-1:W], ep[W-1:0], n, lat, ep);
  endtask

  initial begin
    vecs[0] = '{x: 8'hC8, y: 8'hB4, n: 8'hFB, p: 16'h8CA0};
    vecs[1] = '{x: 8'h00, y: 8'hFE, n: 8'hFF, p: 16'h0000};
    vecs[2] = '{x: 8'hFE, y: 8'hFE, n: 8'hFF, p: 16'hFC04};
    vecs[3] = '{x: 8'hFE, y: 8'hFD, n: 8'hFF, p: 16'hFB06};
    vecs[4] = '{x: 8'h01, y: 8'h01, n: 8'h02, p: 16'h0001};
    vecs[5] = '{x: 8'h80, y: 8'h02, n: 8'h90, p: 16'h0100};
    vecs[6] = '{x: 8'h12, y: 8'h34, n: 8'h40, p: 16'h03A8};
    vecs[7] = '{x: 8'h7F, y: 8'h81, n: 8'hC0, p: 16'h3FFF};
    vecs[8] = '{x: 8'hFE, y: 8'h00, n: 8'hFF, p: 16'h0000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_x = '0; in_y = '0; in_n = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_outs", 32'({out_a, out_q, out_m}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("first_in_ready", 32'(in_ready), 32'd1);

    run_op(vecs[0].x, vecs[0].y, vecs[0].n, vecs[0].p, 5);
    for (int i = 1; i < 9; i++) begin
      run_op(vecs[i].x, vecs[i].y, vecs[i].n, vecs[i].p, 0);
    end

    // out_ready asserted during MUL must not shorten the operation.
    @(negedge clk);
    in_x = 8'h05; in_y = 8'h07; in_n = 8'h09; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (7) begin
      @(posedge clk);
      #1 chk("early_ready_no_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    chk("early_ready_valid", 32'(out_valid), 32'd1);
    chk("early_ready_p", 32'({out_a, out_q}), 32'h0023);
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("early_ready_idle", 32'(in_ready), 32'd1);
    $display("op x=05 y=07 n=09 with early out_ready -> p=%h%h", out_a, out_q);

    // Reset in the middle of MUL discards the operation.
    @(negedge clk);
    in_x = 8'hAA; in_y = 8'h55; in_n = 8'hF0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_outs", 32'({out_a, out_q, out_m}), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("midrst_release", 32'(in_ready), 32'd1);
    $display("reset mid-MUL -> outputs a=%h q=%h m=%h", out_a, out_q, out_m);
    run_op(8'hAA, 8'h55, 8'hF0, 16'h3872, 0);

`ifdef OPERAND_CHECK_EN
    @(negedge clk);
    in_x = 8'h10; in_y = 8'h05; in_n = 8'h10; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("chk_err_set", 32'(err), 32'd1);
    chk("chk_in_ready", 32'(in_ready), 32'd1);
    chk("chk_busy", 32'(busy), 32'd0);
    repeat (10) begin
      @(posedge clk);
      #1 chk("chk_no_valid", 32'(out_valid), 32'd0);
    end
    $display("op x=10 y=05 n=10 rejected err=%0d", err);
    run_op(8'h03, 8'h05, 8'h10, 16'h000F, 0);
    chk("chk_err_clear", 32'(err), 32'd0);
`else
    run_op(8'h05, 8'h03, 8'h00, 16'h000F, 0);
    chk("err_tied", 32'(err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
